// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Capture FIFO for ALU results with sticky carry/overflow flags
//               and a saturating count of accepted operations.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int NUMBITS = 16,
    parameter int DEPTH   = 4,
    parameter int CNTBITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_opcode,
    input  logic [NUMBITS-1:0]         in_result,
    input  logic                       in_carryout,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_opcode,
    output logic [NUMBITS-1:0]         out_result,
    output logic                       out_carryout,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     fifo_level,
    input  logic                       sticky_clear,
    output logic                       sticky_carry,
    output logic                       sticky_overflow,
    output logic [CNTBITS-1:0]         op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 3 + NUMBITS + 3;
    localparam logic [LW-1:0] c_full = LW'(DEPTH);

    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic               r_sticky_carry;
    logic               r_sticky_overflow;
    logic [CNTBITS-1:0] r_op_count;

    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic [EW-1:0]      w_head;

    assign in_ready    = (r_level != c_full) && !reset;
    assign w_out_valid = (r_level != '0) && !reset;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = w_out_valid && out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage is not reset: the level and pointers alone define what is held.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_opcode, in_result, in_carryout, in_overflow, in_zero};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // A new event in the same cycle as a clear takes priority over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_carry    <= 1'b0;
            r_sticky_overflow <= 1'b0;
            r_op_count        <= '0;
        end else begin
            r_sticky_carry    <= (r_sticky_carry & ~sticky_clear) | (w_push & in_carryout);
            r_sticky_overflow <= (r_sticky_overflow & ~sticky_clear) | (w_push & in_overflow);
            if (w_push && (r_op_count != {CNTBITS{1'b1}})) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign out_valid       = w_out_valid;
    assign out_opcode      = w_out_valid ? w_head[EW-1 -: 3]         : 3'b000;
    assign out_result      = w_out_valid ? w_head[3 +: NUMBITS]      : '0;
    assign out_carryout    = w_out_valid ? w_head[2]                 : 1'b0;
    assign out_overflow    = w_out_valid ? w_head[1]                 : 1'b0;
    assign out_zero        = w_out_valid ? w_head[0]                 : 1'b0;
    assign fifo_level      = r_level;
    assign sticky_carry    = r_sticky_carry;
    assign sticky_overflow = r_sticky_overflow;
    assign op_count        = r_op_count;

endmodule
`default_nettype wire
